// File: rtl/stack_queue_ram_ctrl.sv
// LIFO/FIFO buffer controller for an external single-port synchronous RAM with registered RAM interface.
// Optional macro STACK_QUEUE_PEEK_EN adds a Peek input that reads the next entry without removing it.
module stack_queue_ram_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Push,
    input  logic              Pop,
`ifdef STACK_QUEUE_PEEK_EN
    input  logic              Peek,
`endif
    input  logic              Mode,
    input  logic              ClearFlags,
    input  logic [DATA_W-1:0] DataIn,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Empty,
    output logic              Busy,
    output logic [DATA_W-1:0] Value,
    output logic              ValueValid,
    output logic              Overflow,
    output logic              Underflow,
    output logic              ModeQ,
    output logic              RAMEnable,
    output logic              RAMWriteEnable,
    output logic [ADDR_W-1:0] RAMAddress,
    output logic [DATA_W-1:0] RAMDataIn,
    input  logic [DATA_W-1:0] RAMDataOut
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, CAPT} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_C   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_A   = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, next_state;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, read_addr;
    logic              peek_req;
    logic              do_push, do_pop, do_peek, set_ovf, set_unf;

`ifdef STACK_QUEUE_PEEK_EN
    assign peek_req = Peek;
`else
    assign peek_req = 1'b0;
`endif

    assign Full  = (Count == DEPTH_C);
    assign Empty = (Count == '0);
    assign Busy  = (state != IDLE);

    // LIFO reads the entry below the write pointer; FIFO reads at the head.
    assign read_addr = ModeQ ? rd_ptr : wr_ptr - ONE_A;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        next_state = state;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        do_peek    = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case (state)
            IDLE: begin
                if (Push && !Pop) begin
                    if (Full) begin
                        set_ovf = 1'b1;
                    end else begin
                        do_push    = 1'b1;
                        next_state = WRITE;
                    end
                end else if (Pop && !Push) begin
                    if (Empty) begin
                        set_unf = 1'b1;
                    end else begin
                        do_pop     = 1'b1;
                        next_state = READ;
                    end
                end else if (peek_req && !Push && !Pop) begin
                    if (Empty) begin
                        set_unf = 1'b1;
                    end else begin
                        do_peek    = 1'b1;
                        next_state = READ;
                    end
                end
            end
            WRITE:   next_state = IDLE;
            READ:    next_state = CAPT;
            CAPT:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            Count          <= '0;
            Value          <= '0;
            ValueValid     <= 1'b0;
            Overflow       <= 1'b0;
            Underflow      <= 1'b0;
            ModeQ          <= 1'b0;
            RAMEnable      <= 1'b0;
            RAMWriteEnable <= 1'b0;
            RAMAddress     <= '0;
            RAMDataIn      <= '0;
        end else begin
            RAMEnable      <= 1'b0;
            RAMWriteEnable <= 1'b0;
            ValueValid     <= 1'b0;

            if (do_push) begin
                RAMEnable      <= 1'b1;
                RAMWriteEnable <= 1'b1;
                RAMAddress     <= wr_ptr;
                RAMDataIn      <= DataIn;
                wr_ptr         <= wr_ptr + ONE_A;
                Count          <= Count + ONE_C;
            end

            if (do_pop || do_peek) begin
                RAMEnable  <= 1'b1;
                RAMAddress <= read_addr;
            end

            if (do_pop) begin
                Count <= Count - ONE_C;
                if (ModeQ) rd_ptr <= rd_ptr + ONE_A;
                else       wr_ptr <= wr_ptr - ONE_A;
            end

            if (state == CAPT) begin
                Value      <= RAMDataOut;
                ValueValid <= 1'b1;
            end

            // An empty idle buffer re-aligns the FIFO head and follows the Mode switch.
            if (state == IDLE && Empty) begin
                ModeQ  <= Mode;
                rd_ptr <= wr_ptr;
            end

            if (set_ovf)         Overflow <= 1'b1;
            else if (ClearFlags) Overflow <= 1'b0;

            if (set_unf)         Underflow <= 1'b1;
            else if (ClearFlags) Underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stack_queue_ram_ctrl.sv
// Directed bench for stack_queue_ram_ctrl (ADDR_W=2) with a behavioural RAM, a buffer model and a result scoreboard.
module tb_stack_queue_ram_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              Clk = 1'b0;
    logic              Reset, Push, Pop, Mode, ClearFlags;
    logic              Peek;
    logic [DATA_W-1:0] DataIn;
    logic [ADDR_W:0]   Count;
    logic              Full, Empty, Busy, ValueValid, Overflow, Underflow, ModeQ;
    logic [DATA_W-1:0] Value;
    logic              RAMEnable, RAMWriteEnable;
    logic [ADDR_W-1:0] RAMAddress;
    logic [DATA_W-1:0] RAMDataIn;
    logic [DATA_W-1:0] RAMDataOut = '0;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] model [$];
    logic [DATA_W-1:0] sb [$];
    bit                fifo_mode;
    logic [DATA_W-1:0] last_val;
    logic [ADDR_W-1:0] waddr;
    int                total = 0;
    int                bad   = 0;

    always #5 Clk = ~Clk;

    stack_queue_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Push(Push),
        .Pop(Pop),
`ifdef STACK_QUEUE_PEEK_EN
        .Peek(Peek),
`endif
        .Mode(Mode),
        .ClearFlags(ClearFlags),
        .DataIn(DataIn),
        .Count(Count),
        .Full(Full),
        .Empty(Empty),
        .Busy(Busy),
        .Value(Value),
        .ValueValid(ValueValid),
        .Overflow(Overflow),
        .Underflow(Underflow),
        .ModeQ(ModeQ),
        .RAMEnable(RAMEnable),
        .RAMWriteEnable(RAMWriteEnable),
        .RAMAddress(RAMAddress),
        .RAMDataIn(RAMDataIn),
        .RAMDataOut(RAMDataOut)
    );

    always @(posedge Clk) begin
        if (RAMEnable) begin
            if (RAMWriteEnable) mem[RAMAddress] <= RAMDataIn;
            else                RAMDataOut <= mem[RAMAddress];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_push(input logic [DATA_W-1:0] d, output logic [ADDR_W-1:0] wa);
        bit acc;
        acc = (model.size() < DEPTH);
        @(negedge Clk);
        Push   = 1'b1;
        DataIn = d;
        @(negedge Clk);
        Push = 1'b0;
        wa   = RAMAddress;
        if (acc) begin
            model.push_back(d);
            check("push_ram_en", RAMEnable, 1);
            check("push_ram_we", RAMWriteEnable, 1);
            check("push_ram_din", RAMDataIn, d);
            check("push_busy", Busy, 1);
            @(negedge Clk);
        end else begin
            check("ovf_no_ram", RAMEnable, 0);
            check("ovf_flag", Overflow, 1);
        end
        check("push_count", Count, model.size());
    endtask

    task automatic do_pop();
        bit acc;
        int n;
        logic [DATA_W-1:0] exp_v;
        acc = (model.size() > 0);
        @(negedge Clk);
        Pop = 1'b1;
        @(negedge Clk);
        Pop = 1'b0;
        if (acc) begin
            exp_v = fifo_mode ? model.pop_front() : model.pop_back();
            sb.push_back(exp_v);
            check("pop_count", Count, model.size());
            check("pop_ram_we", RAMWriteEnable, 0);
            n = 0;
            while (!ValueValid && n < 8) begin
                @(negedge Clk);
                n++;
            end
            check("pop_vv_seen", ValueValid, 1);
            exp_v = sb.pop_front();
            check("pop_value", Value, exp_v);
            last_val = exp_v;
            @(negedge Clk);
            check("pop_vv_pulse", ValueValid, 0);
        end else begin
            check("unf_flag", Underflow, 1);
            for (int i = 0; i < 3; i++) begin
                check("unf_no_ram", RAMEnable, 0);
                check("unf_no_vv", ValueValid, 0);
                @(negedge Clk);
            end
            check("unf_value_kept", Value, last_val);
            check("unf_idle", Busy, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        model.delete();
        last_val = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Push = 1'b0; Pop = 1'b0; Peek = 1'b0; Mode = 1'b0;
        ClearFlags = 1'b0; DataIn = '0; fifo_mode = 1'b0; last_val = '0;
        do_reset();

        check("rst_empty", Empty, 1);
        check("rst_full", Full, 0);
        check("rst_count", Count, 0);
        check("rst_busy", Busy, 0);
        check("rst_value", Value, 0);
        check("rst_vv", ValueValid, 0);
        check("rst_flags", {Overflow, Underflow}, 0);
        check("rst_modeq", ModeQ, 0);
        check("rst_ram", {RAMEnable, RAMWriteEnable, RAMAddress}, 0);

        // LIFO ordering
        do_push(8'h11, waddr);
        do_push(8'h22, waddr);
        do_push(8'h33, waddr);
        check("lifo_count3", Count, 3);
        do_pop();
        do_pop();
        do_pop();
        check("lifo_drained", Empty, 1);

        // FIFO ordering; the Mode toggle while non-empty must not take effect
        Mode = 1'b1; fifo_mode = 1'b1;
        @(negedge Clk);
        check("fifo_modeq", ModeQ, 1);
        do_push(8'h11, waddr);
        Mode = 1'b0;
        do_push(8'h22, waddr);
        do_push(8'h33, waddr);
        check("fifo_modeq_held", ModeQ, 1);
        do_pop();
        do_pop();
        do_pop();
        check("fifo_drained", Empty, 1);

        // Full and overflow in LIFO
        fifo_mode = 1'b0;
        @(negedge Clk);
        check("lifo_modeq", ModeQ, 0);
        for (int i = 0; i < 4; i++) do_push(8'hA0 + 8'(i), waddr);
        check("full_flag", Full, 1);
        check("full_count", Count, 4);
        do_push(8'hA4, waddr);
        check("ovf_count", Count, 4);
        check("ovf_full", Full, 1);
        do_pop();
        check("ovf_pop_value", Value, 8'hA3);
        ClearFlags = 1'b1;
        @(negedge Clk);
        ClearFlags = 1'b0;
        check("ovf_cleared", Overflow, 0);
        while (model.size() > 0) do_pop();

        // Underflow
        do_pop();
        ClearFlags = 1'b1;
        @(negedge Clk);
        ClearFlags = 1'b0;
        check("unf_cleared", Underflow, 0);

        // FIFO pointer wrap from a fresh reset
        Mode = 1'b1; fifo_mode = 1'b1;
        do_reset();
        @(negedge Clk);
        check("wrap_modeq", ModeQ, 1);
        for (int i = 1; i <= 4; i++) do_push(8'(i), waddr);
        do_pop();
        do_pop();
        do_push(8'h05, waddr);
        check("wrap_addr5", waddr, 0);
        do_push(8'h06, waddr);
        check("wrap_addr6", waddr, 1);
        do_pop();
        check("wrap_v3", last_val, 8'h03);
        do_pop();
        do_pop();
        do_pop();
        check("wrap_v6", Value, 8'h06);
        check("wrap_empty", Empty, 1);

        // Reset during CAPT aborts the read
        do_push(8'h5A, waddr);
        @(negedge Clk);
        Pop = 1'b1;
        @(negedge Clk);
        Pop = 1'b0;
        check("abort_busy_read", Busy, 1);
        @(negedge Clk);
        check("abort_busy_capt", Busy, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model.delete();
        check("abort_idle", Busy, 0);
        check("abort_count", Count, 0);
        check("abort_value", Value, 0);
        check("abort_vv", ValueValid, 0);
        check("abort_ram_en", RAMEnable, 0);
        @(negedge Clk);
        check("abort_vv_next", ValueValid, 0);
        check("abort_ram_next", RAMEnable, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
